// File: rtl/riscv_biu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : riscv_biu_arbiter                                                |
// | Purpose : Shares one downstream BIU between the instruction-fetch port     |
// |           (ibiu_*) and the data port (dbiu_*). One owner at a time; the    |
// |           grant is held across bursts, locked sequences and outstanding    |
// |           data phases. Round-robin on simultaneous requests.               |
// | Ports   : clk_i/rst_i      clock, asynchronous active-high reset           |
// |           ibiu_*/dbiu_*    upstream slave ports (request in, response out) |
// |           biu_*            downstream master port (request out, resp in)   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module riscv_biu_arbiter #(
    parameter int XLEN           = 32,
    parameter int PHYS_ADDR_SIZE = XLEN
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      ibiu_stb_i,
    input  logic [PHYS_ADDR_SIZE-1:0] ibiu_adri_i,
    input  logic [2:0]                ibiu_size_i,
    input  logic [2:0]                ibiu_type_i,
    input  logic [2:0]                ibiu_prot_i,
    input  logic                      ibiu_lock_i,
    input  logic                      ibiu_we_i,
    input  logic [XLEN-1:0]           ibiu_d_i,
    output logic                      ibiu_stb_ack_o,
    output logic                      ibiu_d_ack_o,
    output logic [PHYS_ADDR_SIZE-1:0] ibiu_adro_o,
    output logic [XLEN-1:0]           ibiu_q_o,
    output logic                      ibiu_ack_o,
    output logic                      ibiu_err_o,

    input  logic                      dbiu_stb_i,
    input  logic [PHYS_ADDR_SIZE-1:0] dbiu_adri_i,
    input  logic [2:0]                dbiu_size_i,
    input  logic [2:0]                dbiu_type_i,
    input  logic [2:0]                dbiu_prot_i,
    input  logic                      dbiu_lock_i,
    input  logic                      dbiu_we_i,
    input  logic [XLEN-1:0]           dbiu_d_i,
    output logic                      dbiu_stb_ack_o,
    output logic                      dbiu_d_ack_o,
    output logic [PHYS_ADDR_SIZE-1:0] dbiu_adro_o,
    output logic [XLEN-1:0]           dbiu_q_o,
    output logic                      dbiu_ack_o,
    output logic                      dbiu_err_o,

    output logic                      biu_stb_o,
    output logic [PHYS_ADDR_SIZE-1:0] biu_adri_o,
    output logic [2:0]                biu_size_o,
    output logic [2:0]                biu_type_o,
    output logic [2:0]                biu_prot_o,
    output logic                      biu_lock_o,
    output logic                      biu_we_o,
    output logic [XLEN-1:0]           biu_d_o,
    input  logic                      biu_stb_ack_i,
    input  logic                      biu_d_ack_i,
    input  logic [PHYS_ADDR_SIZE-1:0] biu_adro_i,
    input  logic [XLEN-1:0]           biu_q_i,
    input  logic                      biu_ack_i,
    input  logic                      biu_err_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IGNT = 2'd1,
        ST_DGNT = 2'd2
    } state_t;

    localparam logic       c_GRANT_INSTR = 1'b0;
    localparam logic       c_GRANT_DATA  = 1'b1;
    localparam logic [2:0] c_TYPE_INCR   = 3'd1;

    state_t     r_state, w_state_next;
    logic       r_last_grant, w_last_grant_next;
    logic [4:0] r_beat_cnt, w_beat_cnt_next;
    logic [1:0] r_outstanding, w_outstanding_next;
    logic       r_accepted, w_accepted_next;

    logic       w_granted, w_own_stb, w_own_lock, w_other_stb;
    logic [2:0] w_own_type;
    logic       w_first_accept, w_final_accept, w_release;

    // Beats remaining after the first one, by burst type.
    function automatic logic [4:0] burst_len_m1(input logic [2:0] btype);
        case (btype)
            3'd2, 3'd3: return 5'd3;
            3'd4, 3'd5: return 5'd7;
            3'd6, 3'd7: return 5'd15;
            default:    return 5'd0;
        endcase
    endfunction

    // Select the current owner's request-side controls.
    always_comb begin
        w_granted   = 1'b0;
        w_own_stb   = 1'b0;
        w_own_lock  = 1'b0;
        w_own_type  = 3'd0;
        w_other_stb = 1'b0;
        case (r_state)
            ST_IGNT: begin
                w_granted   = 1'b1;
                w_own_stb   = ibiu_stb_i;
                w_own_lock  = ibiu_lock_i;
                w_own_type  = ibiu_type_i;
                w_other_stb = dbiu_stb_i;
            end
            ST_DGNT: begin
                w_granted   = 1'b1;
                w_own_stb   = dbiu_stb_i;
                w_own_lock  = dbiu_lock_i;
                w_own_type  = dbiu_type_i;
                w_other_stb = ibiu_stb_i;
            end
            default: ;
        endcase
    end

    // Counters, release detection and next state.
    always_comb begin
        w_first_accept  = w_granted && biu_stb_ack_i && !r_accepted;
        w_accepted_next = r_accepted | (w_granted & biu_stb_ack_i);

        if (w_first_accept)
            w_beat_cnt_next = burst_len_m1(w_own_type);
        else if (w_granted && biu_stb_ack_i && (r_beat_cnt != 5'd0))
            w_beat_cnt_next = r_beat_cnt - 5'd1;
        else
            w_beat_cnt_next = r_beat_cnt;

        w_outstanding_next = r_outstanding;
        if (w_granted) begin
            case ({biu_stb_ack_i, (biu_ack_i | biu_err_i)})
                2'b10:   w_outstanding_next = r_outstanding + 2'd1;
                2'b01:   w_outstanding_next = (r_outstanding != 2'd0) ? r_outstanding - 2'd1 : 2'd0;
                default: w_outstanding_next = r_outstanding;
            endcase
        end

        // Fixed-length bursts end on their last accepted beat; INCR only ends
        // when the owner withdraws its strobe.
        w_final_accept = w_granted && biu_stb_ack_i && (w_beat_cnt_next == 5'd0) &&
                         (w_own_type != c_TYPE_INCR);
        w_release      = w_granted && w_accepted_next && (w_beat_cnt_next == 5'd0) &&
                         (w_outstanding_next == 2'd0) && !w_own_lock &&
                         (!w_own_stb || w_final_accept);

        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (ibiu_stb_i && dbiu_stb_i)
                    w_state_next = (r_last_grant == c_GRANT_INSTR) ? ST_DGNT : ST_IGNT;
                else if (ibiu_stb_i)
                    w_state_next = ST_IGNT;
                else if (dbiu_stb_i)
                    w_state_next = ST_DGNT;
            end
            ST_IGNT, ST_DGNT: begin
                if (w_release) begin
                    // Hand over directly to a waiting requester, no IDLE bubble.
                    if (w_other_stb)
                        w_state_next = (r_state == ST_IGNT) ? ST_DGNT : ST_IGNT;
                    else
                        w_state_next = ST_IDLE;
                    w_last_grant_next = (r_state == ST_IGNT) ? c_GRANT_INSTR : c_GRANT_DATA;
                    w_accepted_next   = 1'b0;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= c_GRANT_INSTR;
            r_beat_cnt    <= 5'd0;
            r_outstanding <= 2'd0;
            r_accepted    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_last_grant  <= w_last_grant_next;
            r_beat_cnt    <= w_beat_cnt_next;
            r_outstanding <= w_outstanding_next;
            r_accepted    <= w_accepted_next;
        end
    end

    // Request and response steering; everything is zero while idle.
    always_comb begin
        biu_stb_o      = 1'b0;
        biu_adri_o     = '0;
        biu_size_o     = 3'd0;
        biu_type_o     = 3'd0;
        biu_prot_o     = 3'd0;
        biu_lock_o     = 1'b0;
        biu_we_o       = 1'b0;
        biu_d_o        = '0;
        ibiu_stb_ack_o = 1'b0;
        ibiu_d_ack_o   = 1'b0;
        ibiu_adro_o    = '0;
        ibiu_q_o       = '0;
        ibiu_ack_o     = 1'b0;
        ibiu_err_o     = 1'b0;
        dbiu_stb_ack_o = 1'b0;
        dbiu_d_ack_o   = 1'b0;
        dbiu_adro_o    = '0;
        dbiu_q_o       = '0;
        dbiu_ack_o     = 1'b0;
        dbiu_err_o     = 1'b0;
        case (r_state)
            ST_IGNT: begin
                biu_stb_o      = ibiu_stb_i;
                biu_adri_o     = ibiu_adri_i;
                biu_size_o     = ibiu_size_i;
                biu_type_o     = ibiu_type_i;
                biu_prot_o     = ibiu_prot_i;
                biu_lock_o     = ibiu_lock_i;
                biu_we_o       = ibiu_we_i;
                biu_d_o        = ibiu_d_i;
                ibiu_stb_ack_o = biu_stb_ack_i;
                ibiu_d_ack_o   = biu_d_ack_i;
                ibiu_adro_o    = biu_adro_i;
                ibiu_q_o       = biu_q_i;
                ibiu_ack_o     = biu_ack_i;
                ibiu_err_o     = biu_err_i;
            end
            ST_DGNT: begin
                biu_stb_o      = dbiu_stb_i;
                biu_adri_o     = dbiu_adri_i;
                biu_size_o     = dbiu_size_i;
                biu_type_o     = dbiu_type_i;
                biu_prot_o     = dbiu_prot_i;
                biu_lock_o     = dbiu_lock_i;
                biu_we_o       = dbiu_we_i;
                biu_d_o        = dbiu_d_i;
                dbiu_stb_ack_o = biu_stb_ack_i;
                dbiu_d_ack_o   = biu_d_ack_i;
                dbiu_adro_o    = biu_adro_i;
                dbiu_q_o       = biu_q_i;
                dbiu_ack_o     = biu_ack_i;
                dbiu_err_o     = biu_err_i;
            end
            default: ;
        endcase
    end

    // More than three data phases in flight is a downstream protocol violation.
    a_outstanding_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_granted && (r_outstanding == 2'd3) && biu_stb_ack_i && !(biu_ack_i || biu_err_i)));

endmodule
`default_nettype wire

// File: tb/tb_riscv_biu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
module tb_riscv_biu_arbiter;
    localparam int XLEN = 32;
    localparam int PAS  = 32;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    logic            ibiu_stb_i, ibiu_lock_i, ibiu_we_i;
    logic [PAS-1:0]  ibiu_adri_i;
    logic [2:0]      ibiu_size_i, ibiu_type_i, ibiu_prot_i;
    logic [XLEN-1:0] ibiu_d_i;
    logic            ibiu_stb_ack_o, ibiu_d_ack_o, ibiu_ack_o, ibiu_err_o;
    logic [PAS-1:0]  ibiu_adro_o;
    logic [XLEN-1:0] ibiu_q_o;
    logic            dbiu_stb_i, dbiu_lock_i, dbiu_we_i;
    logic [PAS-1:0]  dbiu_adri_i;
    logic [2:0]      dbiu_size_i, dbiu_type_i, dbiu_prot_i;
    logic [XLEN-1:0] dbiu_d_i;
    logic            dbiu_stb_ack_o, dbiu_d_ack_o, dbiu_ack_o, dbiu_err_o;
    logic [PAS-1:0]  dbiu_adro_o;
    logic [XLEN-1:0] dbiu_q_o;
    logic            biu_stb_o, biu_lock_o, biu_we_o;
    logic [PAS-1:0]  biu_adri_o;
    logic [2:0]      biu_size_o, biu_type_o, biu_prot_o;
    logic [XLEN-1:0] biu_d_o;
    logic            biu_stb_ack_i, biu_d_ack_i, biu_ack_i, biu_err_i;
    logic [PAS-1:0]  biu_adro_i;
    logic [XLEN-1:0] biu_q_i;

    riscv_biu_arbiter #(.XLEN(XLEN), .PHYS_ADDR_SIZE(PAS)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ibiu_stb_i(ibiu_stb_i), .ibiu_adri_i(ibiu_adri_i), .ibiu_size_i(ibiu_size_i),
        .ibiu_type_i(ibiu_type_i), .ibiu_prot_i(ibiu_prot_i), .ibiu_lock_i(ibiu_lock_i),
        .ibiu_we_i(ibiu_we_i), .ibiu_d_i(ibiu_d_i), .ibiu_stb_ack_o(ibiu_stb_ack_o),
        .ibiu_d_ack_o(ibiu_d_ack_o), .ibiu_adro_o(ibiu_adro_o), .ibiu_q_o(ibiu_q_o),
        .ibiu_ack_o(ibiu_ack_o), .ibiu_err_o(ibiu_err_o),
        .dbiu_stb_i(dbiu_stb_i), .dbiu_adri_i(dbiu_adri_i), .dbiu_size_i(dbiu_size_i),
        .dbiu_type_i(dbiu_type_i), .dbiu_prot_i(dbiu_prot_i), .dbiu_lock_i(dbiu_lock_i),
        .dbiu_we_i(dbiu_we_i), .dbiu_d_i(dbiu_d_i), .dbiu_stb_ack_o(dbiu_stb_ack_o),
        .dbiu_d_ack_o(dbiu_d_ack_o), .dbiu_adro_o(dbiu_adro_o), .dbiu_q_o(dbiu_q_o),
        .dbiu_ack_o(dbiu_ack_o), .dbiu_err_o(dbiu_err_o),
        .biu_stb_o(biu_stb_o), .biu_adri_o(biu_adri_o), .biu_size_o(biu_size_o),
        .biu_type_o(biu_type_o), .biu_prot_o(biu_prot_o), .biu_lock_o(biu_lock_o),
        .biu_we_o(biu_we_o), .biu_d_o(biu_d_o), .biu_stb_ack_i(biu_stb_ack_i),
        .biu_d_ack_i(biu_d_ack_i), .biu_adro_i(biu_adro_i), .biu_q_i(biu_q_i),
        .biu_ack_i(biu_ack_i), .biu_err_i(biu_err_i)
    );

    typedef struct packed { logic err; logic [31:0] adr; logic [31:0] q; } resp_t;
    typedef struct packed { logic err; logic [31:0] adr; } slv_t;

    resp_t i_exp[$];
    resp_t d_exp[$];
    slv_t  slv_q[$];

    int n_assert = 0, n_fail = 0, cyc = 0;
    int i_left, d_left;
    int i_acks, d_acks, i_errs, d_errs, i_stb_acks, d_stb_acks;
    int i_first_acc, d_first_acc, i_last_resp, d_last_resp, first_stb_cyc, req_cyc;
    logic        i_sacc, d_sacc;
    logic [31:0] acc_adr;
    logic [31:0] err_adr;

    localparam logic [2:0] SINGLE = 3'd0, WRAP4 = 3'd2, INCR4 = 3'd3, WRAP8 = 3'd4;

    function automatic logic [31:0] slv_data(input logic [31:0] a);
        return 32'hDEADBEEF ^ (a - 32'h100);
    endfunction

    function automatic logic out_any();
        return |{biu_stb_o, biu_adri_o, biu_size_o, biu_type_o, biu_prot_o, biu_lock_o,
                 biu_we_o, biu_d_o, ibiu_stb_ack_o, ibiu_d_ack_o, ibiu_adro_o, ibiu_q_o,
                 ibiu_ack_o, ibiu_err_o, dbiu_stb_ack_o, dbiu_d_ack_o, dbiu_adro_o,
                 dbiu_q_o, dbiu_ack_o, dbiu_err_o};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        ibiu_stb_i = 0; ibiu_lock_i = 0; ibiu_we_i = 0; ibiu_adri_i = 0;
        ibiu_size_i = 0; ibiu_type_i = 0; ibiu_prot_i = 0; ibiu_d_i = 0;
        dbiu_stb_i = 0; dbiu_lock_i = 0; dbiu_we_i = 0; dbiu_adri_i = 0;
        dbiu_size_i = 0; dbiu_type_i = 0; dbiu_prot_i = 0; dbiu_d_i = 0;
        biu_stb_ack_i = 0; biu_d_ack_i = 0; biu_ack_i = 0; biu_err_i = 0;
        biu_adro_i = 0; biu_q_i = 0;
        i_exp.delete(); d_exp.delete(); slv_q.delete();
        i_left = 0; d_left = 0; err_adr = 32'hFFFF_FFFF;
    endtask

    task automatic reset_counts();
        i_acks = 0; d_acks = 0; i_errs = 0; d_errs = 0; i_stb_acks = 0; d_stb_acks = 0;
        i_first_acc = -1; d_first_acc = -1; i_last_resp = -1; d_last_resp = -1;
        first_stb_cyc = -1; req_cyc = cyc;
    endtask

    // Expected responses are queued as soon as a request is driven.
    task automatic issue_i(input logic [31:0] adr, input logic [2:0] btype, input int beats);
        logic [31:0] a;
        ibiu_stb_i = 1; ibiu_adri_i = adr; ibiu_type_i = btype; ibiu_size_i = 3'd2;
        ibiu_prot_i = 3'b101; ibiu_lock_i = 0; ibiu_we_i = 0; i_left = beats;
        for (int k = 0; k < beats; k++) begin
            a = adr + 32'(4 * k);
            i_exp.push_back({(a == err_adr), a, (a == err_adr) ? 32'h0 : slv_data(a)});
        end
    endtask

    task automatic issue_d(input logic [31:0] adr, input logic [2:0] btype, input int beats,
                           input logic we, input logic lock);
        logic [31:0] a;
        dbiu_stb_i = 1; dbiu_adri_i = adr; dbiu_type_i = btype; dbiu_size_i = 3'd2;
        dbiu_prot_i = 3'b001; dbiu_lock_i = lock; dbiu_we_i = we;
        dbiu_d_i = adr ^ 32'h0F0F_0F0F; d_left = beats;
        for (int k = 0; k < beats; k++) begin
            a = adr + 32'(4 * k);
            d_exp.push_back({(a == err_adr), a, (a == err_adr) ? 32'h0 : slv_data(a)});
        end
    endtask

    task automatic monitor();
        resp_t r;
        i_sacc = ibiu_stb_ack_o; d_sacc = dbiu_stb_ack_o; acc_adr = biu_adri_o;
        if (biu_stb_o && first_stb_cyc < 0) first_stb_cyc = cyc;
        check("one_owner", ibiu_stb_ack_o & dbiu_stb_ack_o, 0);
        if (ibiu_stb_ack_o) begin
            i_stb_acks++;
            if (i_first_acc < 0) i_first_acc = cyc;
            check("i_adri_pass", biu_adri_o, ibiu_adri_i);
            check("d_quiet_on_i", |{dbiu_d_ack_o, dbiu_ack_o, dbiu_err_o, dbiu_q_o, dbiu_adro_o}, 0);
        end
        if (dbiu_stb_ack_o) begin
            d_stb_acks++;
            if (d_first_acc < 0) d_first_acc = cyc;
            check("d_adri_pass", biu_adri_o, dbiu_adri_i);
            check("d_dack", dbiu_d_ack_o, dbiu_we_i);
            check("d_lock_pass", biu_lock_o, dbiu_lock_i);
            if (dbiu_we_i) check("d_wdata", biu_d_o, dbiu_d_i);
            check("i_quiet_on_d", |{ibiu_d_ack_o, ibiu_ack_o, ibiu_err_o, ibiu_q_o, ibiu_adro_o}, 0);
        end
        if (ibiu_ack_o || ibiu_err_o) begin
            i_last_resp = cyc;
            if (ibiu_ack_o) i_acks++;
            if (ibiu_err_o) i_errs++;
            check("i_resp_expected", i_exp.size() != 0, 1);
            if (i_exp.size() != 0) begin
                r = i_exp.pop_front();
                check("i_err", ibiu_err_o, r.err);
                check("i_adro", ibiu_adro_o, r.adr);
                check("i_q", ibiu_q_o, r.q);
            end
        end
        if (dbiu_ack_o || dbiu_err_o) begin
            d_last_resp = cyc;
            if (dbiu_ack_o) d_acks++;
            if (dbiu_err_o) d_errs++;
            check("d_resp_expected", d_exp.size() != 0, 1);
            if (d_exp.size() != 0) begin
                r = d_exp.pop_front();
                check("d_err", dbiu_err_o, r.err);
                check("d_adro", dbiu_adro_o, r.adr);
                check("d_q", dbiu_q_o, r.q);
            end
        end
    endtask

    // One clock cycle: slave answers, outputs are checked, requesters advance.
    task automatic step();
        slv_t e;
        #1;
        biu_stb_ack_i = biu_stb_o;
        biu_d_ack_i   = biu_stb_o & biu_we_o;
        if (slv_q.size() != 0) begin
            e = slv_q[0];
            biu_ack_i = !e.err; biu_err_i = e.err; biu_adro_i = e.adr;
            biu_q_i = e.err ? 32'h0 : slv_data(e.adr);
        end else begin
            biu_ack_i = 0; biu_err_i = 0; biu_adro_i = 0; biu_q_i = 0;
        end
        #1;
        monitor();
        @(posedge clk);
        if (biu_ack_i || biu_err_i) slv_q.delete(0);
        if (biu_stb_ack_i) begin
            e.adr = acc_adr; e.err = (acc_adr == err_adr);
            slv_q.push_back(e);
        end
        @(negedge clk);
        cyc++;
        if (i_sacc && i_left > 0) begin
            i_left--;
            if (i_left == 0) begin ibiu_stb_i = 0; ibiu_lock_i = 0; end
            else ibiu_adri_i = ibiu_adri_i + 32'd4;
        end
        if (d_sacc && d_left > 0) begin
            d_left--;
            if (d_left == 0) begin dbiu_stb_i = 0; dbiu_lock_i = 0; end
            else begin dbiu_adri_i = dbiu_adri_i + 32'd4; dbiu_d_i = dbiu_adri_i ^ 32'h0F0F_0F0F; end
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!(i_left == 0 && d_left == 0 && i_exp.size() == 0 && d_exp.size() == 0 &&
                 slv_q.size() == 0) && n < 200) begin
            step();
            n++;
        end
        check({tag, "_finished_in_time"}, n < 200, 1);
        #1;
        check({tag, "_idle_after"}, {biu_stb_o, biu_adri_o}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1;
        clear_all();
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs_zero", out_any(), 0);
        @(negedge clk);
        rst_i = 0;
        #1;
        check("post_rst_outputs_zero", out_any(), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 0;
        clear_all();
        do_reset();

        // Single instruction read.
        reset_counts();
        issue_i(32'h100, SINGLE, 1);
        wait_done("t1");
        check("t1_latency", 64'(first_stb_cyc - req_cyc), 1);
        check("t1_i_acks", 64'(i_acks), 1);
        check("t1_d_stb_acks", 64'(d_stb_acks), 0);

        // Simultaneous requests after reset: data wins, then instruction.
        do_reset();
        reset_counts();
        issue_i(32'h200, WRAP4, 4);
        issue_d(32'h300, SINGLE, 1, 1'b0, 1'b0);
        wait_done("t2");
        check("t2_d_first", d_first_acc < i_first_acc, 1);
        check("t2_handover", 64'(i_first_acc), 64'(d_last_resp + 1));
        check("t2_i_acks", 64'(i_acks), 4);
        check("t2_d_acks", 64'(d_acks), 1);

        // Data request arrives during an instruction WRAP8.
        reset_counts();
        issue_i(32'h400, WRAP8, 8);
        for (int n = 0; n < 50 && i_stb_acks < 2; n++) step();
        issue_d(32'h500, SINGLE, 1, 1'b1, 1'b0);
        wait_done("t3");
        check("t3_i_acks", 64'(i_acks), 8);
        check("t3_d_after_i", 64'(d_first_acc), 64'(i_last_resp + 1));

        // Locked pair of data writes blocks the instruction port.
        reset_counts();
        issue_d(32'h600, SINGLE, 2, 1'b1, 1'b1);
        step();
        issue_i(32'h680, SINGLE, 1);
        wait_done("t4");
        check("t4_d_acks", 64'(d_acks), 2);
        check("t4_i_after_unlock", 64'(i_first_acc), 64'(d_last_resp + 1));

        // Error on beat 2 of a data INCR4 does not end the burst.
        reset_counts();
        err_adr = 32'h704;
        issue_d(32'h700, INCR4, 4, 1'b0, 1'b0);
        step();
        issue_i(32'h800, SINGLE, 1);
        wait_done("t5");
        check("t5_d_errs", 64'(d_errs), 1);
        check("t5_d_acks", 64'(d_acks), 3);
        check("t5_i_errs", 64'(i_errs), 0);
        check("t5_i_after_d", 64'(i_first_acc), 64'(d_last_resp + 1));
        err_adr = 32'hFFFF_FFFF;

        // Asynchronous reset in the middle of an instruction WRAP4.
        reset_counts();
        issue_i(32'h900, WRAP4, 4);
        for (int n = 0; n < 50 && i_stb_acks < 2; n++) step();
        #2;
        check("t6_busy_before_rst", biu_stb_o, 1);
        rst_i = 1;
        #1;
        check("t6_async_rst_zero", out_any(), 0);
        clear_all();
        @(negedge clk);
        rst_i = 0;
        #1;
        check("t6_post_rst_zero", out_any(), 0);
        @(negedge clk);
        reset_counts();
        issue_d(32'hA00, SINGLE, 1, 1'b0, 1'b0);
        wait_done("t6");
        check("t6_latency", 64'(first_stb_cyc - req_cyc), 1);
        check("t6_d_acks", 64'(d_acks), 1);
        check("t6_i_acks", 64'(i_acks), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
